// File: rtl/fuzz_round_ctrl.sv
// Round controller for a fuzzing harness: sequences reload, core reset hold,
// the run phase and a one-cycle report. While the core runs, it raises a
// software interrupt when coverage stalls or the watchdog expires.
module fuzz_round_ctrl #(
    parameter int unsigned MAX_WAIT_CYCLE = 1000,
    parameter int unsigned WATCHDOG_LIMIT = 50000,
    parameter int unsigned MAX_CYCLES     = 2000000000,
    parameter int unsigned RESET_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        reload_done,
    input  logic [63:0] tohost,
    input  logic [29:0] cov,
    output logic        core_reset,
    output logic        interrupt,
    output logic        busy,
    output logic        round_valid,
    output logic [1:0]  round_status,
    output logic [63:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_REPORT
    } state_t;

    localparam logic [7:0]  HOLD_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [63:0] MAX_CYCLES_W = 64'(MAX_CYCLES);
    localparam logic [63:0] WD_LIMIT_W   = 64'(WATCHDOG_LIMIT);
    localparam logic [63:0] MAX_WAIT_W   = 64'(MAX_WAIT_CYCLE);
    localparam logic [1:0]  STATUS_PASS    = 2'd0;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd1;

    state_t      state_q, state_d;
    logic [7:0]  holdCnt_q, holdCnt_d;
    logic [63:0] cycleCnt_q, cycleCnt_d;
    logic [63:0] stallCnt_q, stallCnt_d;
    logic [63:0] watchdog_q, watchdog_d;
    logic [29:0] preCov_q, preCov_d;
    logic [1:0]  status_q, status_d;

    logic [63:0] stallLimit;
    logic        unusedTohost;

    // Only bit 0 of tohost carries the pass flag; the rest is deliberately ignored.
    assign unusedTohost = ^tohost[63:1];

    // Stall limit scales with the coverage summary's upper field; 64-bit product cannot overflow.
    assign stallLimit = MAX_WAIT_W * (64'(cov[29:19]) + 64'd1);

    // State and counter registers; reset aborts any round without reporting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            holdCnt_q  <= '0;
            cycleCnt_q <= '0;
            stallCnt_q <= '0;
            watchdog_q <= '0;
            preCov_q   <= '0;
            status_q   <= STATUS_PASS;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            cycleCnt_q <= cycleCnt_d;
            stallCnt_q <= stallCnt_d;
            watchdog_q <= watchdog_d;
            preCov_q   <= preCov_d;
            status_q   <= status_d;
        end
    end

    // Next-state logic: round sequencing plus the RUN-phase counters.
    always_comb begin
        state_d    = state_q;
        holdCnt_d  = holdCnt_q;
        cycleCnt_d = cycleCnt_q;
        stallCnt_d = stallCnt_q;
        watchdog_d = watchdog_q;
        preCov_d   = preCov_q;
        status_d   = status_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    cycleCnt_d = '0;
                    stallCnt_d = '0;
                    watchdog_d = '0;
                    preCov_d   = '0;
                end
            end
            ST_LOAD: begin
                if (reload_done) begin
                    state_d   = ST_HOLD;
                    holdCnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    cycleCnt_d = 64'd1;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (cov != preCov_q) begin
                    preCov_d   = cov;
                    stallCnt_d = '0;
                end else if (stallCnt_q != '1) begin
                    stallCnt_d = stallCnt_q + 64'd1;
                end
                if (watchdog_q != '1) begin
                    watchdog_d = watchdog_q + 64'd1;
                end
                if (tohost[0]) begin
                    state_d  = ST_REPORT;
                    status_d = STATUS_PASS;
                end else if (cycleCnt_q >= MAX_CYCLES_W) begin
                    state_d  = ST_REPORT;
                    status_d = STATUS_TIMEOUT;
                end else begin
                    cycleCnt_d = cycleCnt_q + 64'd1;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state; interrupt also looks at the live coverage field.
    always_comb begin
        core_reset   = (state_q != ST_RUN);
        busy         = (state_q != ST_IDLE);
        round_valid  = (state_q == ST_REPORT);
        round_status = status_q;
        cycle_count  = cycleCnt_q;
        interrupt    = (state_q == ST_RUN) &&
                       ((stallCnt_q >= stallLimit) || (watchdog_q >= WD_LIMIT_W));
    end

endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// Bench for fuzz_round_ctrl: directed rounds with literal expectations plus a
// per-cycle comparison against a behavioural model of the round controller.
module tb_fuzz_round_ctrl;

    localparam int MW  = 4;
    localparam int WDL = 20;
    localparam int MC  = 50;
    localparam int RC  = 2;

    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_HOLD   = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_REPORT = 4;

    logic        clock;
    logic        reset;
    logic        start;
    logic        reload_done;
    logic [63:0] tohost;
    logic [29:0] cov;
    logic        core_reset;
    logic        interrupt;
    logic        busy;
    logic        round_valid;
    logic [1:0]  round_status;
    logic [63:0] cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    fuzz_round_ctrl #(
        .MAX_WAIT_CYCLE(MW),
        .WATCHDOG_LIMIT(WDL),
        .MAX_CYCLES    (MC),
        .RESET_CYCLES  (RC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .reload_done (reload_done),
        .tohost      (tohost),
        .cov         (cov),
        .core_reset  (core_reset),
        .interrupt   (interrupt),
        .busy        (busy),
        .round_valid (round_valid),
        .round_status(round_status),
        .cycle_count (cycle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: count it, and report it if the DUT disagrees.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          modelOn = 1'b0;
    int          mPhase  = PH_IDLE;
    int          mHold   = 0;
    logic [63:0] mCount  = '0;
    longint      mWd     = 0;
    logic [1:0]  mStatus = 2'd0;
    logic [29:0] covSeq[$];

    // Stall = how many consecutive RUN samples repeated the previous coverage value,
    // with the round starting from an implicit previous value of zero.
    function automatic longint trailingStall();
        longint n = 0;
        for (int i = covSeq.size() - 1; i > 0; i--) begin
            if (covSeq[i] == covSeq[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    // Advance the model on every clock using the inputs the DUT sees.
    always @(posedge clock) begin
        if (reset) begin
            modelOn = 1'b1;
            mPhase  = PH_IDLE;
            mCount  = '0;
            mWd     = 0;
            mStatus = 2'd0;
            covSeq.delete();
            covSeq.push_back(30'd0);
        end else begin
            case (mPhase)
                PH_IDLE: if (start) begin
                    mPhase = PH_LOAD;
                    mCount = '0;
                    mWd    = 0;
                    covSeq.delete();
                    covSeq.push_back(30'd0);
                end
                PH_LOAD: if (reload_done) begin
                    mPhase = PH_HOLD;
                    mHold  = 0;
                end
                PH_HOLD: begin
                    mHold++;
                    if (mHold == RC) begin
                        mPhase = PH_RUN;
                        mCount = 64'd1;
                    end
                end
                PH_RUN: begin
                    covSeq.push_back(cov);
                    mWd++;
                    if (tohost[0]) begin
                        mPhase  = PH_REPORT;
                        mStatus = 2'd0;
                    end else if (mCount >= 64'(MC)) begin
                        mPhase  = PH_REPORT;
                        mStatus = 2'd1;
                    end else begin
                        mCount = mCount + 64'd1;
                    end
                end
                default: mPhase = PH_IDLE;
            endcase
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clock) begin
        if (modelOn) begin
            logic expIrq;
            expIrq = (mPhase == PH_RUN) &&
                     ((trailingStall() >= longint'(MW) * (longint'(cov[29:19]) + 1)) || (mWd >= WDL));
            checkOutput("core_reset", core_reset, mPhase != PH_RUN);
            checkOutput("busy", busy, mPhase != PH_IDLE);
            checkOutput("round_valid", round_valid, mPhase == PH_REPORT);
            checkOutput("cycle_count", cycle_count, mCount);
            checkOutput("interrupt", interrupt, expIrq);
            if (mPhase == PH_REPORT) checkOutput("round_status", round_status, mStatus);
        end
    end

    // ---------------- stimulus ----------------
    int          rHold, rLow, rFirst, rValid, rRise, rFall;
    logic [63:0] rCount;
    logic [1:0]  rStatus;
    logic        rBusyAfter;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic rd);
        reset       = rst;
        start       = st;
        reload_done = rd;
        step();
    endtask

    // Start a round and hold reload_done low for loadWait cycles before completing it.
    task automatic beginRound(input int loadWait);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < loadWait; i++) begin
            checkOutput("load.core_reset", core_reset, 1'b1);
            checkOutput("load.busy", busy, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        reload_done = 1'b0;
    endtask

    // Drive a round from HOLD to its report. covMode 0: hold covBase; 1: toggle bit 0
    // every cycle; 2: flip bit 0 from RUN cycle changeAt onwards.
    task automatic runRound(input int passAt, input int covMode, input logic [29:0] covBase,
                            input int changeAt, input bit pulseStart);
        bit done = 1'b0;
        bit prevIrq = 1'b0;
        int k;
        rHold = 0; rLow = 0; rFirst = -1; rValid = 0; rRise = 0; rFall = 0;
        rCount = '0; rStatus = 2'd3; rBusyAfter = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (round_valid) begin
                rValid++;
                rCount  = cycle_count;
                rStatus = round_status;
                tohost  = '0;
                start   = 1'b0;
                step();
                rBusyAfter = busy;
                done = 1'b1;
            end else if (!core_reset) begin
                k = int'(cycle_count);
                if (rLow == 0) rFirst = k;
                rLow++;
                if (covMode == 1)                      cov = (k % 2 == 1) ? covBase : covBase ^ 30'h1;
                else if (covMode == 2 && k >= changeAt) cov = covBase ^ 30'h1;
                else                                   cov = covBase;
                tohost = {32'hDEAD_BEEF, 31'h0, (k == passAt)};
                start  = pulseStart && (k % 3 == 0);
                #1;
                if (interrupt && !prevIrq && rRise == 0) rRise = k;
                if (!interrupt && prevIrq && rFall == 0) rFall = k;
                prevIrq = interrupt;
                step();
            end else begin
                if (rLow == 0) rHold++;
                start = 1'b0;
                step();
            end
        end
        if (!done) checkOutput("round.finished", 64'd0, 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; reload_done = 1'b0; tohost = '0; cov = '0;
        step();
        step();
        $display("[TB] reset state");
        checkOutput("rst.core_reset", core_reset, 1'b1);
        checkOutput("rst.interrupt", interrupt, 1'b0);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.round_valid", round_valid, 1'b0);
        checkOutput("rst.round_status", round_status, 2'd0);
        checkOutput("rst.cycle_count", cycle_count, 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rst.overrides_start", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] pass in RUN cycle 10");
        beginRound(0);
        runRound(10, 1, 30'h155, 0, 1'b0);
        checkOutput("pass.hold_cycles", rHold, RC);
        checkOutput("pass.low_cycles", rLow, 10);
        checkOutput("pass.first_count", rFirst, 1);
        checkOutput("pass.valid_pulses", rValid, 1);
        checkOutput("pass.count", rCount, 10);
        checkOutput("pass.status", rStatus, 2'd0);
        checkOutput("pass.busy_after", rBusyAfter, 1'b0);

        $display("[TB] timeout");
        beginRound(0);
        runRound(0, 1, 30'h155, 0, 1'b0);
        checkOutput("timeout.low_cycles", rLow, MC);
        checkOutput("timeout.count", rCount, MC);
        checkOutput("timeout.status", rStatus, 2'd1);

        $display("[TB] pass and timeout together");
        beginRound(0);
        runRound(MC, 1, 30'h155, 0, 1'b0);
        checkOutput("tie.count", rCount, MC);
        checkOutput("tie.status", rStatus, 2'd0);

        $display("[TB] stall, cov held 0");
        beginRound(0);
        runRound(12, 0, 30'h0, 0, 1'b0);
        checkOutput("stall0.rise_cycle", rRise, 5);

        $display("[TB] stall, cov held 0x80000");
        beginRound(0);
        runRound(14, 0, 30'h80000, 0, 1'b0);
        checkOutput("stall8.rise_cycle", rRise, 10);

        $display("[TB] stall then cov change");
        beginRound(0);
        runRound(11, 2, 30'h0, 8, 1'b0);
        checkOutput("change.rise_cycle", rRise, 5);
        checkOutput("change.fall_cycle", rFall, 9);

        $display("[TB] watchdog");
        beginRound(0);
        runRound(30, 1, 30'h0, 0, 1'b0);
        checkOutput("wd.rise_cycle", rRise, 21);
        checkOutput("wd.fall_cycle", rFall, 0);

        $display("[TB] slow reload, start pulses while running");
        beginRound(7);
        runRound(6, 1, 30'h2A, 0, 1'b1);
        checkOutput("hs.low_cycles", rLow, 6);
        checkOutput("hs.count", rCount, 6);
        checkOutput("hs.valid_pulses", rValid, 1);
        checkOutput("hs.busy_after", rBusyAfter, 1'b0);

        $display("[TB] reset mid-run");
        beginRound(0);
        begin
            bit found = 1'b0;
            cov = 30'h0;
            for (int t = 0; t < 40 && !found; t++) begin
                if (!core_reset && cycle_count == 64'd5) found = 1'b1;
                else step();
            end
            checkOutput("abort.reached_cycle5", found, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.core_reset", core_reset, 1'b1);
        checkOutput("abort.interrupt", interrupt, 1'b0);
        checkOutput("abort.round_valid", round_valid, 1'b0);
        checkOutput("abort.cycle_count", cycle_count, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        beginRound(0);
        runRound(3, 1, 30'h155, 0, 1'b0);
        checkOutput("restart.first_count", rFirst, 1);
        checkOutput("restart.count", rCount, 3);
        checkOutput("restart.valid_pulses", rValid, 1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fuzz_round_ctrl.md
FUZZ_ROUND_CTRL -- requirements
Module: fuzz_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT_CYCLE, default 1000: base coverage-stall limit in cycles.
REQ-002 SHALL have parameter WATCHDOG_LIMIT, default 50000: RUN cycles before a forced interrupt.
REQ-003 SHALL have parameter MAX_CYCLES, default 2000000000: RUN cycles before a round times out.
REQ-004 SHALL have parameter RESET_CYCLES, default 4: core-reset hold after reload, range 1..255.
REQ-005 SHALL have port clock, input, 1: the single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port start, input, 1: request a new round; sampled only in IDLE.
REQ-008 SHALL have port reload_done, input, 1: harness finished memory/cosim reload.
REQ-009 SHALL have port tohost, input, 64: core tohost value; bit 0 high means pass.
REQ-010 SHALL have port cov, input, 30: coverage summary from the DUT.
REQ-011 SHALL have port core_reset, output, 1: reset driven to the DUT.
REQ-012 SHALL have port interrupt, output, 1: software-interrupt request to the core.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port round_valid, output, 1: one-cycle end-of-round pulse.
REQ-015 SHALL have port round_status, output, 2: 0 = pass, 1 = timeout; valid with round_valid and held until the next round.
REQ-016 SHALL have port cycle_count, output, 64: RUN cycles in the current or last round.

Function
REQ-017 SHALL implement the states IDLE, LOAD, HOLD, RUN and REPORT.
REQ-018 IDLE SHALL go to LOAD on start=1, and at the same time clear cycle_count, the stall counter, the watchdog and pre_cov; with start=0 it SHALL stay in IDLE.
REQ-019 LOAD SHALL wait for reload_done=1, then go to HOLD; start SHALL be ignored outside IDLE.
REQ-020 HOLD SHALL last exactly RESET_CYCLES cycles, then go to RUN.
REQ-021 core_reset SHALL be 1 in IDLE, LOAD, HOLD and REPORT, and 0 only in RUN.
REQ-022 In RUN, cycle_count SHALL increment by 1 every cycle, so it equals 1 in the first RUN cycle.
REQ-023 In RUN, if tohost[0]=1 the next state SHALL be REPORT with status 0, and cycle_count SHALL include that cycle.
REQ-024 In RUN, if tohost[0]=0 and cycle_count has reached MAX_CYCLES this cycle, the next state SHALL be REPORT with status 1.
REQ-025 If a pass and a timeout occur in the same cycle, pass SHALL win.
REQ-026 REPORT SHALL last exactly 1 cycle with round_valid=1 and cycle_count frozen, then go to IDLE.
REQ-027 In RUN, if cov differs from pre_cov, then pre_cov SHALL load cov and the stall counter SHALL clear to 0; otherwise the stall counter SHALL increment, saturating at all-ones.
REQ-028 In RUN, the watchdog SHALL increment every cycle, saturating at all-ones.
REQ-029 The stall threshold SHALL be MAX_WAIT_CYCLE*(cov[29:19]+1), computed at 64-bit width with no overflow.
REQ-030 interrupt SHALL be 1 only in RUN when (stall counter >= threshold) or (watchdog >= WATCHDOG_LIMIT).
REQ-031 interrupt SHALL be combinational from registered counters and cov only, and SHALL be 0 in all other states.
REQ-032 The stall counter and watchdog SHALL be 64 bits wide.
REQ-033 tohost bits [63:1] SHALL be ignored.

Reset
REQ-034 While reset=1 at posedge, the next state SHALL be IDLE, and reset SHALL override every other input.
REQ-035 After reset: core_reset=1, interrupt=0, busy=0, round_valid=0, round_status=0, cycle_count=0, all counters 0, pre_cov=0.
REQ-036 Reset asserted mid-round (any state) SHALL abort the round without a round_valid pulse.

Verification (MAX_WAIT_CYCLE=4, WATCHDOG_LIMIT=20, MAX_CYCLES=50, RESET_CYCLES=2)
REQ-037 Pass: start, reload_done one cycle later, tohost=1 in the 10th RUN cycle -> core_reset low for exactly 10 cycles, round_valid one cycle with status 0 and cycle_count=10, busy falls the next cycle.
REQ-038 Timeout: tohost held 0 -> REPORT after 50 RUN cycles with status 1 and cycle_count=50; with tohost=1 in cycle 50 -> status 0 and cycle_count=50.
REQ-039 Stall: cov held at 0 -> interrupt rises when the stall counter reaches 4; cov=30'h80000 -> rises at 8; a cov change -> interrupt drops the next cycle.
REQ-040 Watchdog: cov toggling every cycle -> interrupt rises at watchdog=20 and stays high until REPORT.
REQ-041 Handshake: reload_done held 0 for 7 cycles -> state stays LOAD with core_reset=1; start pulses during RUN -> no effect.
REQ-042 Reset mid-RUN at cycle 5 -> next cycle IDLE, core_reset=1, interrupt=0, no round_valid; next start -> cycle_count restarts at 1.
